cla_serial_adder: RTL and testbench
===================================

// Module: cla_serial_adder
//
// PURPOSE
//   Wide multi-cycle adder. Adds WIDTH-bit operands 4 bits per cycle through a
//   single instance of the team's 4-bit carry-lookahead cell (CLA_4bit).
//   Sits directly upstream of that cell: registers the operands, feeds one
//   nibble per cycle with the registered carry, and collects each nibble sum.
//   Valid/ready handshake on both the input side and the output side.
//
// PARAMETERS
//   WIDTH   16   operand/sum width; multiple of 4, >= 4
//   NCHUNK  WIDTH/4 (localparam)   number of CLA passes per operation
//
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active-low
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry in
//   out_valid  out  1      sum/cout valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  registered sum
//   cout       out  1      registered carry out of MSB
//   busy       out  1      high in RUN or DONE
//
// BEHAVIOUR
//   - FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE); busy = !in_ready.
//   - IDLE: on in_valid&&in_ready, latch a, b into shift regs; carry_q<=cin;
//     cnt<=0; go to RUN. Without in_valid, stay in IDLE.
//   - RUN, each cycle: CLA inputs = a_sh[3:0], b_sh[3:0], carry_q.
//     Shift a_sh and b_sh right by 4. Shift the CLA sum into sum_sh[WIDTH-1 -: 4]
//     (sum_sh shifts right by 4). carry_q<=CLA cout. cnt<=cnt+1.
//     When cnt==NCHUNK-1, load sum<=final sum_sh, cout<=CLA cout, go to DONE.
//   - DONE: out_valid=1. sum and cout hold stable while !out_ready.
//     On out_ready, go to IDLE (out_valid drops on the next cycle).
//   - Latency: operands are accepted at edge k; out_valid is high from edge
//     k+NCHUNK. Back-to-back throughput is one operation per NCHUNK+2 cycles.
//   - in_valid, a, b and cin are ignored outside IDLE. out_ready is ignored
//     outside DONE.
//   - Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.
//   - WIDTH=4: a single RUN cycle; the result is identical to one CLA pass.
//   - Reset (asynchronous assert at any time, including mid-RUN or DONE):
//     state=IDLE, out_valid=0, sum=0, cout=0, carry_q=0, cnt=0, all shift
//     regs=0. Any in-flight operation is dropped and produces no output.
//     Deassertion is synchronised externally.
//
// CONFIGURATION
//   CLA_SERIAL_OVF_EN defined:
//     - Adds output port ovf (1 bit): signed two's-complement overflow.
//       ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), with A and B taken from
//       the operands latched at acceptance.
//     - ovf is computed as MSB carry-in XOR MSB carry-out.
//     - ovf is registered alongside sum, valid with out_valid, and reset to 0.
//   CLA_SERIAL_OVF_EN not defined: the ovf port and its logic are absent.
//
// TESTING
//   1. WIDTH=16, a=16'h1234, b=16'h4321, cin=0 -> sum=16'h5555, cout=0;
//      out_valid high exactly 4 cycles after accept.
//   2. a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1
//      (carry crosses all 4 chunk boundaries).
//   3. Hold out_ready=0 for 5 cycles in DONE -> sum and cout stable,
//      in_ready=0, a new in_valid is ignored; raise out_ready -> IDLE next cycle.
//   4. Assert rst_n=0 after 2 RUN cycles -> out_valid=0, sum=0, in_ready=1
//      immediately; the next operation a=16'h0001, b=16'h0001 gives sum=16'h0002.
//   5. With CLA_SERIAL_OVF_EN: a=16'h7FFF, b=16'h0001 -> sum=16'h8000, ovf=1,
//      cout=0; a=16'h8000, b=16'h8000 -> sum=16'h0000, cout=1, ovf=1.
//   6. Random 1000 ops, WIDTH=4 and WIDTH=32, random in_valid/out_ready
//      stalls -> every result matches the model a+b+cin; no dropped or
//      duplicated outputs.

Source files
------------

// File: rtl/cla_serial_adder.sv
// -----------------------------------------------------------------------------
// cla_serial_adder
//
// Wide multi-cycle adder. A WIDTH-bit add is performed 4 bits per cycle
// through a single 4-bit carry-lookahead cell (CLA_4bit). Operands are
// latched into shift registers, one nibble per cycle is fed to the cell with
// the registered carry, and each nibble sum is shifted into the top of the
// sum shift register.
//
// Optional feature macro: CLA_SERIAL_OVF_EN
//   When defined, adds output ovf (signed two's-complement overflow of the
//   completed add), registered alongside sum and valid with out_valid.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active-low
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands (IDLE)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry in
//   out_valid  out  1      sum/cout valid (DONE)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  registered sum
//   cout       out  1      registered carry out of MSB
//   busy       out  1      high in RUN or DONE
//   ovf        out  1      signed overflow (only with CLA_SERIAL_OVF_EN)
//   dbg_state  out  2      current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and its data stable until that edge;
// ready may depend only on the receiver's state, never on valid.
// -----------------------------------------------------------------------------

// 4-bit carry-lookahead cell.
module CLA_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s_o = p ^ c[3:0];
  assign c_o = c[4];
endmodule

module cla_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
`ifdef CLA_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / 4;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [3:0]       cla_s;
  logic             cla_co;
  logic [WIDTH-1:0] sum_sh_next;

  CLA_4bit u_cla (
    .a_i (a_sh_q[3:0]),
    .b_i (b_sh_q[3:0]),
    .c_i (carry_q),
    .s_o (cla_s),
    .c_o (cla_co)
  );

  // New nibble enters at the top so after NCHUNK passes the first nibble
  // (the least significant) has reached bit 0.
  assign sum_sh_next = (sum_sh_q >> 4) | (WIDTH'(cla_s) << (WIDTH - 4));

`ifdef CLA_SERIAL_OVF_EN
  logic ovf_q, ovf_d;
  logic msb_cin;
  // Carry into the MSB recovered from the sum bit: s = a ^ b ^ c.
  assign msb_cin = a_sh_q[3] ^ b_sh_q[3] ^ cla_s[3];
`endif

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef CLA_SERIAL_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          sum_sh_d = '0;
          carry_d  = cin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        sum_sh_d = sum_sh_next;
        carry_d  = cla_co;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          sum_d   = sum_sh_next;
          cout_d  = cla_co;
`ifdef CLA_SERIAL_OVF_EN
          ovf_d   = msb_cin ^ cla_co;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

`ifdef CLA_SERIAL_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign busy      = !in_ready;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_serial_adder
//
// Bench for cla_serial_adder: a WIDTH=16 instance for directed scenarios and
// WIDTH=4 / WIDTH=32 instances for randomised traffic with stalls on both
// sides. Expected {cout,sum} values are computed from the operands with
// plain integer addition and queued at acceptance; they are popped when the
// DUT hands a result over.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cla_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- WIDTH=16 instance ----------------
  logic        in_valid16 = 1'b0, out_ready16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        in_ready16, out_valid16, cout16, busy16;
  logic [15:0] sum16;
  logic [1:0]  st16;
`ifdef CLA_SERIAL_OVF_EN
  logic        ovf16;
`endif

  cla_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .cout(cout16), .busy(busy16),
`ifdef CLA_SERIAL_OVF_EN
    .ovf(ovf16),
`endif
    .dbg_state(st16)
  );

  // ---------------- WIDTH=4 instance ----------------
  logic        in_valid4 = 1'b0, out_ready4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        in_ready4, out_valid4, cout4, busy4;
  logic [3:0]  sum4;
  logic [1:0]  st4;
`ifdef CLA_SERIAL_OVF_EN
  logic        ovf4;
`endif

  cla_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .cout(cout4), .busy(busy4),
`ifdef CLA_SERIAL_OVF_EN
    .ovf(ovf4),
`endif
    .dbg_state(st4)
  );

  // ---------------- WIDTH=32 instance ----------------
  logic        in_valid32 = 1'b0, out_ready32 = 1'b0, cin32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        in_ready32, out_valid32, cout32, busy32;
  logic [31:0] sum32;
  logic [1:0]  st32;
`ifdef CLA_SERIAL_OVF_EN
  logic        ovf32;
`endif

  cla_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin32), .out_valid(out_valid32),
    .out_ready(out_ready32), .sum(sum32), .cout(cout32), .busy(busy32),
`ifdef CLA_SERIAL_OVF_EN
    .ovf(ovf32),
`endif
    .dbg_state(st32)
  );

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  function automatic logic [32:0] model_add(input int w, input logic [31:0] ta,
                                            input logic [31:0] tb, input logic tc);
    longint unsigned s;
    longint unsigned mask;
    mask = (64'd1 << (w + 1)) - 64'd1;
    s = longint'(ta) + longint'(tb) + longint'(tc);
    return 33'(s & mask);
  endfunction

  // ---------------- WIDTH=16 driver ----------------
  // Runs one full operation; returns cycles from accept edge to out_valid.
  task automatic run16(input logic [15:0] ta, input logic [15:0] tb,
                       input logic tc, output int lat);
    logic [32:0] exp;
    logic [32:0] got;
    int cyc;
    @(negedge clk);
    a16 = ta; b16 = tb; cin16 = tc; in_valid16 = 1'b1; out_ready16 = 1'b0;
    cyc = 0;
    while (!in_ready16 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    exp_q.push_back(model_add(16, 32'(ta), 32'(tb), tc));
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (!out_valid16) begin
      n_miss++;
      $display("FAIL run16_timeout: out_valid=%0b after %0d cycles, required 1", out_valid16, lat);
      exp_q.delete();
    end else begin
      exp = exp_q.pop_front();
      got = 33'({cout16, sum16});
      if (got !== exp) begin
        n_miss++;
        $display("FAIL run16_result a=%h b=%h cin=%0b: got %h required %h", ta, tb, tc, got, exp);
      end
    end
    @(negedge clk);
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid16, sum16, cout16, in_ready16, busy16, st16} !== {1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 2'd0}) begin
      n_miss++;
      $display("FAIL reset_w16: ov=%0b sum=%h cout=%0b ir=%0b busy=%0b st=%0d required 0/0000/0/1/0/0",
               out_valid16, sum16, cout16, in_ready16, busy16, st16);
    end
    n_vec++;
    if ({out_valid4, sum4, cout4, in_ready4, out_valid32, sum32, cout32, in_ready32} !==
        {1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      n_miss++;
      $display("FAIL reset_w4_w32: ov4=%0b sum4=%h ir4=%0b ov32=%0b sum32=%h ir32=%0b required idle zeros",
               out_valid4, sum4, in_ready4, out_valid32, sum32, in_ready32);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    run16(16'h1234, 16'h4321, 1'b0, lat);
    n_vec++;
    if (lat !== 4) begin
      n_miss++;
      $display("FAIL latency_w16: got %0d cycles required 4", lat);
    end
`ifdef CLA_SERIAL_OVF_EN
    n_vec++;
    if (ovf16 !== 1'b0) begin
      n_miss++;
      $display("FAIL ovf_none: got %0b required 0", ovf16);
    end
`endif
    run16(16'hFFFF, 16'h0000, 1'b1, lat);
    run16(16'h0F0F, 16'h00F1, 1'b0, lat);
    run16(16'hFFFF, 16'hFFFF, 1'b1, lat);
    run16(16'h8000, 16'h7FFF, 1'b1, lat);
    run16(16'h0000, 16'h0000, 1'b0, lat);
  endtask

  task automatic test_back_to_back;
    int lat;
    for (int i = 0; i < 8; i++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), lat);
    end
  endtask

  task automatic test_hold;
    logic [32:0] exp;
    int cyc;
    exp = model_add(16, 32'h0000ABCD, 32'h00009876, 1'b1);
    @(negedge clk);
    a16 = 16'hABCD; b16 = 16'h9876; cin16 = 1'b1; in_valid16 = 1'b1; out_ready16 = 1'b0;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    cyc = 0;
    while (!out_valid16 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    // A competing request while the result is parked must be ignored.
    @(negedge clk);
    a16 = 16'h1111; b16 = 16'h1111; cin16 = 1'b0; in_valid16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid16, in_ready16, cout16, sum16} !== {1'b1, 1'b0, exp[16:0]}) begin
        n_miss++;
        $display("FAIL hold_cycle%0d: ov=%0b ir=%0b result=%h required ov=1 ir=0 result=%h",
                 i, out_valid16, in_ready16, {cout16, sum16}, exp[16:0]);
      end
    end
    @(negedge clk);
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    n_vec++;
    if ({out_valid16, in_ready16} !== 2'b01) begin
      n_miss++;
      $display("FAIL hold_release: ov=%0b ir=%0b required 0 1", out_valid16, in_ready16);
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (busy16 !== 1'b0) begin
      n_miss++;
      $display("FAIL hold_ignored_request: busy=%0b required 0", busy16);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    // Reset after two RUN cycles.
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid16, sum16, cout16, in_ready16, busy16} !== {1'b0, 16'h0, 1'b0, 1'b1, 1'b0}) begin
      n_miss++;
      $display("FAIL reset_mid_run: ov=%0b sum=%h cout=%0b ir=%0b busy=%0b required 0/0000/0/1/0",
               out_valid16, sum16, cout16, in_ready16, busy16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run16(16'h0001, 16'h0001, 1'b0, lat);
    // Reset while a non-zero result is parked in DONE.
    @(negedge clk);
    a16 = 16'hF00D; b16 = 16'h1234; cin16 = 1'b1; in_valid16 = 1'b1; out_ready16 = 1'b0;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid16, sum16, cout16, in_ready16} !== {1'b0, 16'h0, 1'b0, 1'b1}) begin
      n_miss++;
      $display("FAIL reset_in_done: ov=%0b sum=%h cout=%0b ir=%0b required 0/0000/0/1",
               out_valid16, sum16, cout16, in_ready16);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef CLA_SERIAL_OVF_EN
  task automatic test_ovf;
    int lat;
    run16(16'h7FFF, 16'h0001, 1'b0, lat);
    n_vec++;
    if (ovf16 !== 1'b1) begin
      n_miss++;
      $display("FAIL ovf_pos: got %0b required 1", ovf16);
    end
    run16(16'h8000, 16'h8000, 1'b0, lat);
    n_vec++;
    if (ovf16 !== 1'b1) begin
      n_miss++;
      $display("FAIL ovf_neg: got %0b required 1", ovf16);
    end
    run16(16'hFFFF, 16'h0001, 1'b0, lat);
    n_vec++;
    if (ovf16 !== 1'b0) begin
      n_miss++;
      $display("FAIL ovf_mixed_sign: got %0b required 0", ovf16);
    end
  endtask
`endif

  // ---------------- random traffic on WIDTH=4 / WIDTH=32 ----------------
  task automatic set_in(input int w, input logic v, input logic [31:0] ta,
                        input logic [31:0] tb, input logic tc);
    if (w == 4) begin
      in_valid4 = v; a4 = ta[3:0]; b4 = tb[3:0]; cin4 = tc;
    end else begin
      in_valid32 = v; a32 = ta; b32 = tb; cin32 = tc;
    end
  endtask

  task automatic set_out_ready(input int w, input logic v);
    if (w == 4) out_ready4 = v;
    else        out_ready32 = v;
  endtask

  function automatic logic get_in_ready(input int w);
    return (w == 4) ? in_ready4 : in_ready32;
  endfunction

  function automatic logic get_out_valid(input int w);
    return (w == 4) ? out_valid4 : out_valid32;
  endfunction

  function automatic logic [32:0] get_result(input int w);
    return (w == 4) ? 33'({cout4, sum4}) : {cout32, sum32};
  endfunction

  task automatic test_random(input int w, input int nops);
    int sent = 0;
    int rcv = 0;
    int budget = 40 * nops;
    exp_q.delete();
    fork
      begin : driver
        logic        pending = 1'b0;
        logic [31:0] ta = '0;
        logic [31:0] tb = '0;
        logic        tc = 1'b0;
        int cyc = 0;
        while (sent < nops && cyc < budget) begin
          @(negedge clk);
          cyc++;
          if (!pending && $urandom_range(0, 3) != 0) begin
            ta = $urandom; tb = $urandom; tc = 1'($urandom_range(0, 1));
            if (w == 4) begin
              ta = ta & 32'hF; tb = tb & 32'hF;
            end
            pending = 1'b1;
          end
          set_in(w, pending, ta, tb, tc);
          if (pending && get_in_ready(w)) begin
            exp_q.push_back(model_add(w, ta, tb, tc));
            sent++;
            pending = 1'b0;
          end
        end
        @(negedge clk);
        set_in(w, 1'b0, 32'h0, 32'h0, 1'b0);
      end
      begin : monitor
        int cyc = 0;
        logic [32:0] exp;
        logic [32:0] got;
        logic        rdy;
        while (rcv < nops && cyc < budget) begin
          @(negedge clk);
          cyc++;
          rdy = ($urandom_range(0, 1) != 0);
          set_out_ready(w, rdy);
          if (rdy && get_out_valid(w)) begin
            n_vec++;
            got = get_result(w);
            if (exp_q.size() == 0) begin
              n_miss++;
              $display("FAIL random_w%0d_extra_output: got %h with no outstanding operation", w, got);
            end else begin
              exp = exp_q.pop_front();
              if (got !== exp) begin
                n_miss++;
                $display("FAIL random_w%0d_result #%0d: got %h required %h", w, rcv, got, exp);
              end
            end
            rcv++;
          end
        end
        @(negedge clk);
        set_out_ready(w, 1'b0);
      end
    join
    n_vec++;
    if (rcv != nops || exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL random_w%0d_count: received %0d with %0d outstanding, required %0d with 0",
               w, rcv, exp_q.size(), nops);
    end
    // No further result may appear once all results have been consumed.
    set_out_ready(w, 1'b1);
    repeat (3 * (w / 4) + 4) @(posedge clk);
    #1;
    n_vec++;
    if (get_out_valid(w) !== 1'b0) begin
      n_miss++;
      $display("FAIL random_w%0d_duplicate: out_valid=1 after all results consumed", w);
    end
    set_out_ready(w, 1'b0);
    exp_q.delete();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_reset_mid();
`ifdef CLA_SERIAL_OVF_EN
    test_ovf();
`endif
    test_random(4, 500);
    test_random(32, 500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
